sram_bank_ctrl: RTL and testbench
=================================

// Module: sram_bank_ctrl
// PURPOSE
//   Parametrised single-port synchronous SRAM bank with valid/ready request port, per-byte write
//   enables, 1- or 2-cycle pipelined read response, sequential hardware clear engine (power-up
//   and on demand) and out-of-range error reporting. Next-generation on-chip buffer bank: drops
//   the CE/WE/RE strobe interface and the per-entry flop reset in favour of a handshake and an
//   init FSM.
// PARAMETERS
//   ADDR_WIDTH    8           address bits
//   DATA_WIDTH    32          word width; must be a multiple of 8
//   DEPTH         1<<ADDR_WIDTH  implemented words; 1 .. 2**ADDR_WIDTH
//   READ_LATENCY  1           cycles from read acceptance to rsp_valid; legal values 1 or 2
//   INIT_VALUE    0           DATA_WIDTH word written to every entry by the clear engine
// PORTS
//   clk        in   1               clock, all logic on rising edge
//   reset_n    in   1               asynchronous, active-low reset
//   req_valid  in   1               request present
//   req_ready  out  1               controller accepts a request this cycle
//   req_write  in   1               1 = write, 0 = read
//   req_addr   in   ADDR_WIDTH      word address
//   req_wdata  in   DATA_WIDTH      write data
//   req_be     in   DATA_WIDTH/8    byte enables (bit i -> bits 8i+7:8i)
//   clear_req  in   1               pulse: re-initialise whole array to INIT_VALUE
//   rsp_valid  out  1               read data valid (single-cycle pulse per read, no backpressure)
//   rsp_rdata  out  DATA_WIDTH      read data; 0 when rsp_valid=0
//   rsp_err    out  1               with rsp_valid: read address was >= DEPTH
//   init_done  out  1               array holds defined contents; high in READY
// BEHAVIOUR
//   Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; FSM -> INIT, clear
//     counter=0, read pipeline flushed. Array contents are NOT reset by reset_n.
//   FSM states:
//     INIT:  one entry per cycle; mem[cnt] <= INIT_VALUE; cnt++.
//            After writing DEPTH-1 -> READY. INIT lasts exactly DEPTH cycles.
//            req_ready=0; clear_req ignored.
//     READY: req_ready=1 and init_done=1 unless clear is pending.
//            clear_req=1 -> DRAIN (or straight to INIT if the read pipeline is empty).
//            req_ready is driven low in the cycle clear_req is sampled; no request is accepted
//            in that cycle.
//     DRAIN: req_ready=0, init_done=0; wait until all in-flight reads have responded -> INIT (cnt=0).
//   Acceptance: transfer when req_valid && req_ready at a rising edge; one request max per cycle.
//   Write: at the accepting edge, update only the byte lanes with req_be=1. No response.
//     be=0 performs no update.
//   Read: rsp_valid pulses exactly READY_LATENCY cycles after the accepting edge, with that
//     entry's contents at the accepting edge. Back-to-back reads give back-to-back responses.
//   Ordering: a read accepted the cycle after a write to the same address returns the new data.
//     Single port, so a same-cycle collision cannot occur.
//   Out-of-range (addr >= DEPTH): write discarded with no array change. Read still responds at
//     normal latency with rsp_rdata=0, rsp_err=1. rsp_err=0 on in-range reads.
//   Reset mid-operation: in-flight responses are dropped (no rsp_valid after reset_n rises).
//     INIT restarts at address 0.
//   clear_req while in INIT or DRAIN: no effect (no restart, no queuing).
// TESTING
//   1. Reset release, DEPTH=256:
//      req_ready=0 for exactly 256 cycles, then init_done=1.
//      Reads of addr 0, 128 and 255 return 0x00000000 with rsp_err=0.
//   2. Write 0xDEADBEEF to 0x10 with be=4'b1111, then write 0x11223344 to 0x10 with be=4'b0101.
//      A subsequent read of 0x10 returns 0xDE22BE44.
//   3. Latency:
//      - READ_LATENCY=1: reads to 1, 2, 3 on consecutive cycles -> rsp_valid high 3 consecutive
//        cycles, starting 1 cycle after the first acceptance, data in order.
//      - READ_LATENCY=2: same stimulus, responses start 2 cycles after the first acceptance.
//   4. DEPTH=200, ADDR_WIDTH=8:
//      - Write 0xAAAAAAAA to addr 250.
//      - Read 250 -> rsp_rdata=0, rsp_err=1.
//      - Read 199 -> INIT_VALUE, rsp_err=0.
//   5. Pulse clear_req while a read is in flight (READ_LATENCY=2):
//      - The pending rsp_valid still arrives.
//      - req_ready then stays low for DEPTH cycles.
//      - Previously written 0x10 then reads INIT_VALUE.
//   6. Assert reset_n=0 midway through INIT (cnt=100) and also with a read pending:
//      - No rsp_valid appears.
//      - After release, INIT takes a full DEPTH cycles.
//      - All entries read INIT_VALUE.

Source files
------------

// File: rtl/sram_bank_ctrl.sv
// Single-port synchronous SRAM bank with a valid/ready request port and byte-lane writes.
// Reads respond after a pipeline of 1 or 2 cycles, and a sequential clear engine initialises the array.
module sram_bank_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 1 << ADDR_WIDTH,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [ADDR_WIDTH-1:0]     req_addr_i,
   input  logic [DATA_WIDTH-1:0]     req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   req_be_i,
   input  logic                      clear_req_i,
   output logic                      rsp_valid_o,
   output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      init_done_o
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {ST_INIT, ST_READY, ST_DRAIN} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic                    ready_q;
   logic                    init_done_q;
   logic                    s1_valid_q;
   logic                    s1_err_q;
   logic [DATA_WIDTH-1:0]   s1_data_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    accept;
   logic                    in_range;
   logic                    rd_accept;
   logic                    wr_accept;
   logic                    pending;
   logic [DATA_WIDTH-1:0]   rd_word;

   // A clear sampled this cycle blocks acceptance in the same cycle.
   assign req_ready_o = ready_q & ~clear_req_i;
   assign init_done_o = init_done_q;

   assign accept    = req_valid_i & req_ready_o;
   assign in_range  = {1'b0, req_addr_i} < DEPTH_W;
   assign rd_accept = accept & ~req_write_i;
   assign wr_accept = accept & req_write_i & in_range;
   assign rd_word   = in_range ? mem_q[req_addr_i] : '0;
   assign pending   = (READ_LATENCY == 2) ? s1_valid_q : 1'b0;

   // Array storage: no reset; the clear engine owns it while in INIT.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[cnt_q] <= INIT_VALUE;
      end else if (wr_accept) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (req_be_i[b]) mem_q[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
         end
      end
   end

   // First read stage captures the entry contents at the accepting edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_accept;
         s1_err_q   <= rd_accept & ~in_range;
         s1_data_q  <= rd_accept ? rd_word : '0;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  rsp_valid_q;
      logic                  rsp_err_q;
      logic [DATA_WIDTH-1:0] rsp_data_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
         end else begin
            rsp_valid_q <= s1_valid_q;
            rsp_err_q   <= s1_err_q;
            rsp_data_q  <= s1_data_q;
         end
      end

      assign rsp_valid_o = rsp_valid_q;
      assign rsp_err_o   = rsp_err_q;
      assign rsp_rdata_o = rsp_data_q;
   end else begin : g_lat1
      assign rsp_valid_o = s1_valid_q;
      assign rsp_err_o   = s1_err_q;
      assign rsp_rdata_o = s1_data_q;
   end

   // Control FSM: INIT sweeps the array, READY serves requests, DRAIN lets reads finish.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == LAST_ADDR) begin
                  state_q     <= ST_READY;
                  cnt_q       <= '0;
                  ready_q     <= 1'b1;
                  init_done_q <= 1'b1;
               end
            end
            ST_READY: begin
               if (clear_req_i) begin
                  state_q     <= pending ? ST_DRAIN : ST_INIT;
                  cnt_q       <= '0;
                  ready_q     <= 1'b0;
                  init_done_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!pending) state_q <= ST_INIT;
            end
            default: begin
               state_q <= ST_INIT;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl: a default bank (256 words, 1-cycle reads) and a
// 200-word, 2-cycle bank share one stimulus stream and are checked against hand-computed values.
module tb_sram_bank_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid, write, clear;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic        a_ready, a_rv, a_err, a_done;
   logic [31:0] a_rd;
   logic        b_ready, b_rv, b_err, b_done;
   logic [31:0] b_rd;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   sram_bank_ctrl u_a (
      .clk(clk), .reset_n(reset_n),
      .req_valid_i(valid), .req_ready_o(a_ready), .req_write_i(write),
      .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .clear_req_i(clear),
      .rsp_valid_o(a_rv), .rsp_rdata_o(a_rd), .rsp_err_o(a_err), .init_done_o(a_done)
   );

   sram_bank_ctrl #(.DEPTH(200), .READ_LATENCY(2)) u_b (
      .clk(clk), .reset_n(reset_n),
      .req_valid_i(valid), .req_ready_o(b_ready), .req_write_i(write),
      .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .clear_req_i(clear),
      .rsp_valid_o(b_rv), .rsp_rdata_o(b_rd), .rsp_err_o(b_err), .init_done_o(b_done)
   );

   // Expected response encoding: {valid, err, data}
   typedef struct {
      bit          vld;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [33:0] exp_a;
      logic [33:0] exp_b;
   } vec_t;

   localparam logic [33:0] NONE = 34'h0;
   localparam logic [33:0] ERR  = {2'b11, 32'h0};

   function automatic logic [33:0] rsp(input logic [31:0] d);
      return {2'b10, d};
   endfunction

   function automatic vec_t mk(input bit vld, input bit wr, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] e,
                               input logic [33:0] ea, input logic [33:0] eb);
      vec_t v;
      v.vld = vld; v.wr = wr; v.addr = a; v.wd = d; v.be = e; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles until each bank raises req_ready; optionally pulses clear_req at cycle clr_at.
   task automatic wait_ready(input int clr_at, output int ca, output int cb, output bit saw_rsp);
      ca = -1; cb = -1; saw_rsp = 1'b0;
      for (int i = 1; i <= 600 && (ca < 0 || cb < 0); i++) begin
         clear = (i == clr_at);
         step();
         clear = 1'b0;
         if (a_rv || b_rv) saw_rsp = 1'b1;
         if (ca < 0 && a_ready) ca = i;
         if (cb < 0 && b_ready) cb = i;
      end
   endtask

   task automatic rd_both(input string name, input logic [7:0] a,
                          input logic [33:0] ea, input logic [33:0] eb);
      valid = 1'b1; write = 1'b0; addr = a;
      step();
      valid = 1'b0;
      check({name, "_a"}, {a_rv, a_err, a_rd}, ea);
      step();
      check({name, "_b"}, {b_rv, b_err, b_rd}, eb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [20];
      logic [33:0] prev_b;
      int          ca, cb;
      bit          saw, saw_pre;

      tbl[0]  = mk(1, 1, 8'h10, 32'hDEADBEEF, 4'hF, NONE, NONE);
      tbl[1]  = mk(1, 1, 8'h10, 32'h11223344, 4'h5, NONE, NONE);
      tbl[2]  = mk(1, 0, 8'h10, 32'h0, 4'h0, rsp(32'hDE22BE44), rsp(32'hDE22BE44));
      tbl[3]  = mk(1, 0, 8'h00, 32'h0, 4'h0, rsp(32'h0), rsp(32'h0));
      tbl[4]  = mk(1, 0, 8'h80, 32'h0, 4'h0, rsp(32'h0), rsp(32'h0));
      tbl[5]  = mk(1, 0, 8'hFF, 32'h0, 4'h0, rsp(32'h0), ERR);
      tbl[6]  = mk(1, 1, 8'hFA, 32'hAAAAAAAA, 4'hF, NONE, NONE);
      tbl[7]  = mk(1, 0, 8'hFA, 32'h0, 4'h0, rsp(32'hAAAAAAAA), ERR);
      tbl[8]  = mk(1, 0, 8'hC7, 32'h0, 4'h0, rsp(32'h0), rsp(32'h0));
      tbl[9]  = mk(1, 1, 8'h01, 32'h01010101, 4'hF, NONE, NONE);
      tbl[10] = mk(1, 1, 8'h02, 32'h02020202, 4'hF, NONE, NONE);
      tbl[11] = mk(1, 1, 8'h03, 32'h03030303, 4'hF, NONE, NONE);
      tbl[12] = mk(1, 0, 8'h01, 32'h0, 4'h0, rsp(32'h01010101), rsp(32'h01010101));
      tbl[13] = mk(1, 0, 8'h02, 32'h0, 4'h0, rsp(32'h02020202), rsp(32'h02020202));
      tbl[14] = mk(1, 0, 8'h03, 32'h0, 4'h0, rsp(32'h03030303), rsp(32'h03030303));
      tbl[15] = mk(1, 1, 8'h03, 32'hFFFFFFFF, 4'h0, NONE, NONE);
      tbl[16] = mk(1, 0, 8'h03, 32'h0, 4'h0, rsp(32'h03030303), rsp(32'h03030303));
      tbl[17] = mk(1, 1, 8'h04, 32'hFFFFFFFF, 4'h8, NONE, NONE);
      tbl[18] = mk(1, 0, 8'h04, 32'h0, 4'h0, rsp(32'hFF000000), rsp(32'hFF000000));
      tbl[19] = mk(0, 0, 8'h00, 32'h0, 4'h0, NONE, NONE);

      valid = 1'b0; write = 1'b0; clear = 1'b0; addr = '0; wdata = '0; be = '0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("rst_a", {a_ready, a_rv, a_err, a_done, a_rd}, 64'h0);
      check("rst_b", {b_ready, b_rv, b_err, b_done, b_rd}, 64'h0);
      repeat (3) step();
      reset_n = 1'b1;

      // Power-up sweep length and first contents
      wait_ready(0, ca, cb, saw);
      check("init_len_a", 64'(ca), 64'(256));
      check("init_len_b", 64'(cb), 64'(200));
      check("init_no_rsp", 64'(saw), 64'h0);
      step();
      check("init_done", {a_ready, a_done, b_ready, b_done}, 64'hF);

      // Table-driven traffic; the 2-cycle bank answers one sample later
      prev_b = NONE;
      for (int i = 0; i < 20; i++) begin
         valid = tbl[i].vld; write = tbl[i].wr; addr = tbl[i].addr;
         wdata = tbl[i].wd; be = tbl[i].be;
         step();
         valid = 1'b0;
         check($sformatf("vec%0d_a", i), {a_rv, a_err, a_rd}, tbl[i].exp_a);
         check($sformatf("vec%0d_b", i), {b_rv, b_err, b_rd}, prev_b);
         prev_b = tbl[i].exp_b;
      end

      // Clear with a read still in flight in the 2-cycle bank
      valid = 1'b1; write = 1'b0; addr = 8'h10;
      step();
      valid = 1'b0;
      check("clr_rsp_a", {a_rv, a_err, a_rd}, rsp(32'hDE22BE44));
      clear = 1'b1;
      #1;
      check("clr_ready_gate", {a_ready, b_ready}, 64'h0);
      step();
      clear = 1'b0;
      check("clr_rsp_b", {b_rv, b_err, b_rd}, rsp(32'hDE22BE44));
      check("clr_done_low", {a_done, b_done}, 64'h0);
      wait_ready(50, ca, cb, saw);
      check("clr_len_a", 64'(ca), 64'(256));
      check("clr_len_b", 64'(cb), 64'(201));
      check("clr_no_rsp", 64'(saw), 64'h0);
      rd_both("clr_rd10", 8'h10, rsp(32'h0), rsp(32'h0));
      rd_both("clr_rd04", 8'h04, rsp(32'h0), rsp(32'h0));

      // Reset with a read pending, then again partway through INIT
      valid = 1'b1; write = 1'b1; addr = 8'h20; wdata = 32'h12345678; be = 4'hF;
      step();
      write = 1'b0;
      step();
      valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check("mid_rst_a", {a_ready, a_rv, a_err, a_done, a_rd}, 64'h0);
      check("mid_rst_b", {b_ready, b_rv, b_err, b_done, b_rd}, 64'h0);
      repeat (2) step();
      reset_n = 1'b1;
      saw_pre = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (a_rv || b_rv || a_ready || b_ready) saw_pre = 1'b1;
      end
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      wait_ready(0, ca, cb, saw);
      check("rst_quiet", 64'({saw_pre, saw}), 64'h0);
      check("rst_len_a", 64'(ca), 64'(256));
      check("rst_len_b", 64'(cb), 64'(200));
      rd_both("rst_rd20", 8'h20, rsp(32'h0), rsp(32'h0));
      rd_both("rst_rd10", 8'h10, rsp(32'h0), rsp(32'h0));
      rd_both("rst_rdFF", 8'hFF, rsp(32'h0), ERR);
      rd_both("rst_rdC7", 8'hC7, rsp(32'h0), rsp(32'h0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
